// File: rtl/pusch_slot_scheduler.sv
// pusch_slot_scheduler: sequences DMRS, FFT and RE-mapper work for one PUSCH slot with watchdog and abort
module pusch_slot_scheduler #(
  parameter int TIMEOUT_CYC = 4095,
  parameter int WD_W        = 12
) (
  input  logic        CLK_RE,
  input  logic        RST_RE,
  input  logic        Slot_Start,
  input  logic        Abort,
  input  logic [10:0] Cfg_N_sc,
  input  logic [6:0]  Cfg_N_rb,
  input  logic [3:0]  Cfg_Sym_Start,
  input  logic [3:0]  Cfg_Sym_End,
  input  logic        Map_Sym_Done,
  output logic [10:0] N_sc,
  output logic [6:0]  N_rb,
  output logic [3:0]  Sym_Start,
  output logic [3:0]  Sym_End,
  output logic [3:0]  Sym_Idx,
  output logic        DMRS_Start,
  output logic        FFT_Start,
  output logic        Busy,
  output logic        Slot_Done,
  output logic        Cfg_Err,
  output logic        Timeout_Err,
  output logic        Overrun
);
  typedef enum logic [2:0] {IDLE, DMRS_REQ, DMRS_WAIT, FFT_REQ, FFT_WAIT, DONE} state_t;
  state_t state, state_nxt;
  logic [WD_W-1:0] wd, wd_nxt;
  logic [3:0] sym_idx_nxt;
  logic [11:0] sc_end;
  logic cfg_ok, start_idle, accept, waiting, last, expire;
  assign sc_end = {1'b0, Cfg_N_sc} + {2'b0, Cfg_N_rb, 3'b0} + {3'b0, Cfg_N_rb, 2'b0};
  assign cfg_ok = Cfg_N_rb != 7'd0 && Cfg_N_rb <= 7'd100 && sc_end <= 12'd1200 &&
                  Cfg_Sym_Start <= Cfg_Sym_End && Cfg_Sym_End <= 4'd13;
  assign start_idle = state == IDLE && Slot_Start && !Abort;
  assign accept = start_idle && cfg_ok;
  assign waiting = state == DMRS_WAIT || state == FFT_WAIT;
  assign last = Sym_Idx == Sym_End;
  // a completion arriving on the expiry cycle takes priority over the watchdog
  assign expire = waiting && !Map_Sym_Done && wd == WD_W'(TIMEOUT_CYC - 1);
  always_comb begin
    state_nxt = state;
    sym_idx_nxt = Sym_Idx;
    wd_nxt = wd;
    if (state != IDLE && Abort) begin
      state_nxt = IDLE;
      sym_idx_nxt = '0;
    end else
      case (state)
        IDLE: if (accept) begin
          state_nxt = DMRS_REQ;
          sym_idx_nxt = Cfg_Sym_Start;
        end
        DMRS_REQ: begin
          state_nxt = DMRS_WAIT;
          wd_nxt = '0;
        end
        FFT_REQ: begin
          state_nxt = FFT_WAIT;
          wd_nxt = '0;
        end
        DMRS_WAIT, FFT_WAIT: if (Map_Sym_Done) begin
          state_nxt = last ? DONE : FFT_REQ;
          sym_idx_nxt = last ? Sym_Idx : Sym_Idx + 4'd1;
        end else if (expire) begin
          state_nxt = IDLE;
          sym_idx_nxt = '0;
        end else
          wd_nxt = wd + WD_W'(1);
        default: state_nxt = IDLE;
      endcase
  end
  // pulse outputs are registered from the next state so they line up with the state they announce
  always_ff @(posedge CLK_RE or negedge RST_RE)
    if (!RST_RE) begin
      state <= IDLE;
      wd <= '0;
      N_sc <= '0;
      N_rb <= '0;
      Sym_Start <= '0;
      Sym_End <= '0;
      Sym_Idx <= '0;
      DMRS_Start <= 1'b0;
      FFT_Start <= 1'b0;
      Busy <= 1'b0;
      Slot_Done <= 1'b0;
      Cfg_Err <= 1'b0;
      Timeout_Err <= 1'b0;
      Overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      wd <= wd_nxt;
      Sym_Idx <= sym_idx_nxt;
      DMRS_Start <= state_nxt == DMRS_REQ;
      FFT_Start <= state_nxt == FFT_REQ;
      Slot_Done <= state_nxt == DONE;
      Busy <= !(state_nxt == IDLE || state_nxt == DONE);
      Cfg_Err <= start_idle && !cfg_ok;
      Timeout_Err <= expire && !Abort;
      Overrun <= Slot_Start && state != IDLE;
      if (accept) begin
        N_sc <= Cfg_N_sc;
        N_rb <= Cfg_N_rb;
        Sym_Start <= Cfg_Sym_Start;
        Sym_End <= Cfg_Sym_End;
      end
    end
endmodule

// File: tb/tb_pusch_slot_scheduler.sv
// tb_pusch_slot_scheduler: scoreboard bench for pusch_slot_scheduler (default and short-watchdog instances)
module tb_pusch_slot_scheduler;
  localparam int K_DMRS = 0, K_FFT = 1, K_DONE = 2, K_CFG = 3, K_TO = 4, K_OVR = 5;
  logic CLK_RE = 1'b0, RST_RE = 1'b0;
  logic Slot_Start = 1'b0, Abort = 1'b0, Map_Sym_Done = 1'b0;
  logic [10:0] Cfg_N_sc = '0;
  logic [6:0] Cfg_N_rb = '0;
  logic [3:0] Cfg_Sym_Start = '0, Cfg_Sym_End = '0;
  logic [10:0] N_sc, b_N_sc;
  logic [6:0] N_rb, b_N_rb;
  logic [3:0] Sym_Start, Sym_End, Sym_Idx, b_Sym_Start, b_Sym_End, b_Sym_Idx;
  logic DMRS_Start, FFT_Start, Busy, Slot_Done, Cfg_Err, Timeout_Err, Overrun;
  logic b_DMRS_Start, b_FFT_Start, b_Busy, b_Slot_Done, b_Cfg_Err, b_Timeout_Err, b_Overrun;
  int cyc = 0, total = 0, bad = 0;
  int last_nsc = 0, last_nrb = 0, last_ss = 0, last_se = 0;
  typedef struct {int kind; int sym; int cyc;} ev_t;
  ev_t exp_q[$];
  ev_t mon_e;
  logic [5:0] pulses;
  logic [36:0] a_all;
  assign pulses = {Overrun, Timeout_Err, Cfg_Err, Slot_Done, FFT_Start, DMRS_Start};
  assign a_all = {N_sc, N_rb, Sym_Start, Sym_End, Sym_Idx, DMRS_Start, FFT_Start, Busy,
                  Slot_Done, Cfg_Err, Timeout_Err, Overrun};

  pusch_slot_scheduler dut (
    .CLK_RE(CLK_RE), .RST_RE(RST_RE), .Slot_Start(Slot_Start), .Abort(Abort),
    .Cfg_N_sc(Cfg_N_sc), .Cfg_N_rb(Cfg_N_rb), .Cfg_Sym_Start(Cfg_Sym_Start),
    .Cfg_Sym_End(Cfg_Sym_End), .Map_Sym_Done(Map_Sym_Done), .N_sc(N_sc), .N_rb(N_rb),
    .Sym_Start(Sym_Start), .Sym_End(Sym_End), .Sym_Idx(Sym_Idx), .DMRS_Start(DMRS_Start),
    .FFT_Start(FFT_Start), .Busy(Busy), .Slot_Done(Slot_Done), .Cfg_Err(Cfg_Err),
    .Timeout_Err(Timeout_Err), .Overrun(Overrun));

  pusch_slot_scheduler #(.TIMEOUT_CYC(20), .WD_W(5)) dut_wd (
    .CLK_RE(CLK_RE), .RST_RE(RST_RE), .Slot_Start(Slot_Start), .Abort(Abort),
    .Cfg_N_sc(Cfg_N_sc), .Cfg_N_rb(Cfg_N_rb), .Cfg_Sym_Start(Cfg_Sym_Start),
    .Cfg_Sym_End(Cfg_Sym_End), .Map_Sym_Done(Map_Sym_Done), .N_sc(b_N_sc), .N_rb(b_N_rb),
    .Sym_Start(b_Sym_Start), .Sym_End(b_Sym_End), .Sym_Idx(b_Sym_Idx),
    .DMRS_Start(b_DMRS_Start), .FFT_Start(b_FFT_Start), .Busy(b_Busy),
    .Slot_Done(b_Slot_Done), .Cfg_Err(b_Cfg_Err), .Timeout_Err(b_Timeout_Err),
    .Overrun(b_Overrun));

  always #5 CLK_RE = ~CLK_RE;
  always @(posedge CLK_RE) cyc++;

  // every pulse on the default instance must match the head of the expectation queue
  always @(negedge CLK_RE)
    for (int k = 0; k < 6; k++)
      if (pulses[k]) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected: got kind=%0d sym=%0d cyc=%0d, required no pulse", k, Sym_Idx, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.kind != k || mon_e.cyc != cyc || (mon_e.sym >= 0 && mon_e.sym != int'(Sym_Idx))) begin
            bad++;
            $display("FAIL sb_event: got kind=%0d sym=%0d cyc=%0d, required kind=%0d sym=%0d cyc=%0d",
                     k, Sym_Idx, cyc, mon_e.kind, mon_e.sym, mon_e.cyc);
          end
        end
      end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no end of run, required completion");
    $fatal(1);
  end

  task automatic push_ev(input int k, input int sym, input int c);
    exp_q.push_back('{kind: k, sym: sym, cyc: c});
  endtask

  task automatic at_edge(input int n);
    while (cyc < n - 1) @(negedge CLK_RE);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge CLK_RE);
  endtask

  task automatic drain(input string name);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain_%s: got %0d pending events, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic set_cfg(input int nsc, input int nrb, input int ss, input int se);
    Cfg_N_sc = 11'(nsc);
    Cfg_N_rb = 7'(nrb);
    Cfg_Sym_Start = 4'(ss);
    Cfg_Sym_End = 4'(se);
  endtask

  task automatic pulse_done;
    Map_Sym_Done = 1'b1;
    @(negedge CLK_RE);
    Map_Sym_Done = 1'b0;
  endtask

  task automatic run_slot(input int nsc, input int nrb, input int ss, input int se, input int lat);
    int s, n;
    logic [30:0] want;
    n = se - ss + 1;
    set_cfg(nsc, nrb, ss, se);
    s = cyc + 1;
    push_ev(K_DMRS, ss, s);
    for (int i = 1; i < n; i++) push_ev(K_FFT, ss + i, s + i * lat);
    push_ev(K_DONE, se, s + n * lat);
    Slot_Start = 1'b1;
    @(negedge CLK_RE);
    Slot_Start = 1'b0;
    want = {11'(nsc), 7'(nrb), 4'(ss), 4'(se), 4'(ss), 1'b1};
    total++;
    if ({N_sc, N_rb, Sym_Start, Sym_End, Sym_Idx, Busy} !== want) begin
      bad++;
      $display("FAIL slot_latch: got %h, required %h", {N_sc, N_rb, Sym_Start, Sym_End, Sym_Idx, Busy}, want);
    end
    last_nsc = nsc; last_nrb = nrb; last_ss = ss; last_se = se;
    for (int i = 1; i <= n; i++) begin
      at_edge(s + i * lat);
      if (i == n) begin
        total++;
        if (Busy !== 1'b1) begin
          bad++;
          $display("FAIL busy_before_last: got %b, required 1", Busy);
        end
      end
      pulse_done();
    end
    total++;
    if (Busy !== 1'b0 || Slot_Done !== 1'b1) begin
      bad++;
      $display("FAIL slot_end: got busy=%b done=%b, required busy=0 done=1", Busy, Slot_Done);
    end
    @(negedge CLK_RE);
    drain("slot");
  endtask

  task automatic reject_cfg(input int nsc, input int nrb, input int ss, input int se);
    int s;
    logic [25:0] want;
    set_cfg(nsc, nrb, ss, se);
    s = cyc + 1;
    push_ev(K_CFG, -1, s);
    Slot_Start = 1'b1;
    @(negedge CLK_RE);
    Slot_Start = 1'b0;
    want = {11'(last_nsc), 7'(last_nrb), 4'(last_ss), 4'(last_se)};
    total++;
    if (Busy !== 1'b0 || {N_sc, N_rb, Sym_Start, Sym_End} !== want) begin
      bad++;
      $display("FAIL cfg_reject: got busy=%b cfg=%h, required busy=0 cfg=%h", Busy, {N_sc, N_rb, Sym_Start, Sym_End}, want);
    end
    @(negedge CLK_RE);
    drain("cfg_err");
  endtask

  task automatic test_reset;
    total++;
    if (a_all !== '0 || b_Busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got %h busy_wd=%b, required all zero", a_all, b_Busy);
    end
  endtask

  task automatic test_valid_slot;
    run_slot(24, 4, 2, 5, 50);
  endtask

  task automatic test_single_symbol;
    run_slot(0, 1, 7, 7, 5);
  endtask

  task automatic test_cfg_table;
    int tab [10][4] = '{'{0, 0, 2, 5}, '{1100, 10, 2, 5}, '{24, 4, 9, 4}, '{24, 101, 0, 0},
                        '{24, 4, 3, 14}, '{1153, 4, 0, 0}, '{2047, 127, 0, 0},
                        '{1152, 4, 13, 13}, '{0, 100, 0, 13}, '{1100, 8, 5, 5}};
    for (int i = 0; i < 10; i++) begin
      if (tab[i][1] >= 1 && tab[i][1] <= 100 && tab[i][0] + 12 * tab[i][1] <= 1200 &&
          tab[i][2] <= tab[i][3] && tab[i][3] <= 13)
        run_slot(tab[i][0], tab[i][1], tab[i][2], tab[i][3], 2);
      else
        reject_cfg(tab[i][0], tab[i][1], tab[i][2], tab[i][3]);
    end
  endtask

  task automatic test_overrun;
    int s;
    set_cfg(24, 4, 2, 4);
    s = cyc + 1;
    push_ev(K_DMRS, 2, s);
    push_ev(K_OVR, 2, s + 3);
    push_ev(K_FFT, 3, s + 8);
    push_ev(K_FFT, 4, s + 16);
    push_ev(K_DONE, 4, s + 24);
    push_ev(K_OVR, -1, s + 25);
    Slot_Start = 1'b1;
    @(negedge CLK_RE);
    Slot_Start = 1'b0;
    at_edge(s + 3);
    set_cfg(500, 2, 0, 0);
    Slot_Start = 1'b1;
    @(negedge CLK_RE);
    Slot_Start = 1'b0;
    total++;
    if (Sym_Idx !== 4'd2 || N_sc !== 11'd24 || N_rb !== 7'd4 || Busy !== 1'b1) begin
      bad++;
      $display("FAIL overrun_wait: got idx=%0d nsc=%0d nrb=%0d busy=%b, required idx=2 nsc=24 nrb=4 busy=1",
               Sym_Idx, N_sc, N_rb, Busy);
    end
    at_edge(s + 8); pulse_done();
    at_edge(s + 16); pulse_done();
    at_edge(s + 24); pulse_done();
    Slot_Start = 1'b1;
    @(negedge CLK_RE);
    Slot_Start = 1'b0;
    @(negedge CLK_RE);
    total++;
    if (Busy !== 1'b0 || N_sc !== 11'd24 || Sym_End !== 4'd4) begin
      bad++;
      $display("FAIL overrun_done: got busy=%b nsc=%0d end=%0d, required busy=0 nsc=24 end=4", Busy, N_sc, Sym_End);
    end
    drain("overrun");
    last_nsc = 24; last_nrb = 4; last_ss = 2; last_se = 4;
  endtask

  task automatic test_abort;
    int s;
    set_cfg(24, 4, 1, 4);
    s = cyc + 1;
    push_ev(K_DMRS, 1, s);
    push_ev(K_FFT, 2, s + 10);
    push_ev(K_FFT, 3, s + 20);
    Slot_Start = 1'b1;
    @(negedge CLK_RE);
    Slot_Start = 1'b0;
    at_edge(s + 10); pulse_done();
    at_edge(s + 20); pulse_done();
    wait_cyc(s + 24);
    total++;
    if (Busy !== 1'b1 || Sym_Idx !== 4'd3) begin
      bad++;
      $display("FAIL abort_before: got busy=%b idx=%0d, required busy=1 idx=3", Busy, Sym_Idx);
    end
    Abort = 1'b1;
    Map_Sym_Done = 1'b1;
    @(negedge CLK_RE);
    Abort = 1'b0;
    Map_Sym_Done = 1'b0;
    total++;
    if (Busy !== 1'b0 || Sym_Idx !== 4'd0) begin
      bad++;
      $display("FAIL abort_after: got busy=%b idx=%0d, required busy=0 idx=0", Busy, Sym_Idx);
    end
    repeat (3) @(negedge CLK_RE);
    drain("abort");
    set_cfg(24, 4, 2, 3);
    Abort = 1'b1;
    Slot_Start = 1'b1;
    @(negedge CLK_RE);
    Abort = 1'b0;
    Slot_Start = 1'b0;
    @(negedge CLK_RE);
    pulse_done();
    @(negedge CLK_RE);
    total++;
    if (Busy !== 1'b0 || Sym_Idx !== 4'd0) begin
      bad++;
      $display("FAIL abort_idle: got busy=%b idx=%0d, required busy=0 idx=0", Busy, Sym_Idx);
    end
    drain("abort_idle");
    run_slot(24, 4, 3, 4, 4);
  endtask

  task automatic test_timeout;
    int s;
    RST_RE = 1'b0;
    @(negedge CLK_RE);
    RST_RE = 1'b1;
    @(negedge CLK_RE);
    set_cfg(0, 1, 0, 1);
    s = cyc + 1;
    push_ev(K_DMRS, 0, s);
    push_ev(K_FFT, 1, s + 3);
    Slot_Start = 1'b1;
    @(negedge CLK_RE);
    Slot_Start = 1'b0;
    at_edge(s + 3); pulse_done();
    total++;
    if (b_FFT_Start !== 1'b1) begin
      bad++;
      $display("FAIL wd_fft_start: got %b, required 1", b_FFT_Start);
    end
    wait_cyc(s + 23);
    total++;
    if (b_Timeout_Err !== 1'b0 || b_Busy !== 1'b1) begin
      bad++;
      $display("FAIL wd_early: got to=%b busy=%b, required to=0 busy=1", b_Timeout_Err, b_Busy);
    end
    wait_cyc(s + 24);
    total++;
    if (b_Timeout_Err !== 1'b1 || b_Busy !== 1'b0 || b_Sym_Idx !== 4'd0) begin
      bad++;
      $display("FAIL wd_expire: got to=%b busy=%b idx=%0d, required to=1 busy=0 idx=0", b_Timeout_Err, b_Busy, b_Sym_Idx);
    end
    wait_cyc(s + 25);
    total++;
    if (b_Timeout_Err !== 1'b0 || b_Busy !== 1'b0) begin
      bad++;
      $display("FAIL wd_after: got to=%b busy=%b, required to=0 busy=0", b_Timeout_Err, b_Busy);
    end
    at_edge(s + 26);
    Abort = 1'b1;
    @(negedge CLK_RE);
    Abort = 1'b0;
    @(negedge CLK_RE);
    drain("timeout");
    set_cfg(0, 1, 0, 0);
    s = cyc + 1;
    push_ev(K_DMRS, 0, s);
    push_ev(K_DONE, 0, s + 21);
    Slot_Start = 1'b1;
    @(negedge CLK_RE);
    Slot_Start = 1'b0;
    at_edge(s + 21); pulse_done();
    total++;
    if (b_Slot_Done !== 1'b1 || b_Timeout_Err !== 1'b0) begin
      bad++;
      $display("FAIL wd_done_wins: got done=%b to=%b, required done=1 to=0", b_Slot_Done, b_Timeout_Err);
    end
    @(negedge CLK_RE);
    total++;
    if (b_Timeout_Err !== 1'b0 || b_Busy !== 1'b0) begin
      bad++;
      $display("FAIL wd_done_after: got to=%b busy=%b, required to=0 busy=0", b_Timeout_Err, b_Busy);
    end
    drain("done_wins");
  endtask

  task automatic test_reset_mid_slot;
    int s;
    set_cfg(24, 4, 2, 5);
    s = cyc + 1;
    push_ev(K_DMRS, 2, s);
    Slot_Start = 1'b1;
    @(negedge CLK_RE);
    Slot_Start = 1'b0;
    wait_cyc(s + 3);
    #2 RST_RE = 1'b0;
    #1;
    total++;
    if (a_all !== '0 || b_Busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_slot: got %h busy_wd=%b, required all zero", a_all, b_Busy);
    end
    @(negedge CLK_RE);
    RST_RE = 1'b1;
    repeat (4) @(negedge CLK_RE);
    drain("reset_mid");
  endtask

  initial begin
    repeat (3) @(negedge CLK_RE);
    test_reset();
    RST_RE = 1'b1;
    @(negedge CLK_RE);
    test_valid_slot();
    test_single_symbol();
    test_cfg_table();
    test_overrun();
    test_abort();
    test_timeout();
    test_reset_mid_slot();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pusch_slot_scheduler.md
# pusch_slot_scheduler

Slot-level controller that sequences the PUSCH resource-element mapping chain for one slot. It validates and latches the slot allocation, then starts DMRS mapping on the first allocated symbol. For every following data symbol it releases the FFT/transform-precoding stage and waits for the mapper's per-symbol completion before moving on. It sits between the upper-layer slot trigger and the DMRS generator, FFT stage and RE mapper, and provides watchdog, abort and error reporting.

## Interface
- TIMEOUT_CYC, 4095: maximum cycles spent waiting for one symbol completion
- WD_W, 12: watchdog counter width; must satisfy 2^WD_W > TIMEOUT_CYC
- CLK_RE  in  1  clock
- RST_RE  in  1  asynchronous, active-low reset
- Slot_Start  in  1  one-cycle pulse that requests a slot
- Abort  in  1  synchronous abort, level-sampled every cycle
- Cfg_N_sc  in  11  starting subcarrier
- Cfg_N_rb  in  7  number of allocated RBs
- Cfg_Sym_Start  in  4  first allocated symbol (DMRS symbol)
- Cfg_Sym_End  in  4  last allocated symbol
- Map_Sym_Done  in  1  mapper per-symbol completion pulse
- N_sc  out  11  latched starting subcarrier, fed to the mapper
- N_rb  out  7  latched RB count
- Sym_Start  out  4  latched first symbol
- Sym_End  out  4  latched last symbol
- Sym_Idx  out  4  symbol currently being mapped
- DMRS_Start  out  1  one-cycle DMRS generator start pulse
- FFT_Start  out  1  one-cycle FFT stage start pulse for Sym_Idx
- Busy  out  1  high while a slot is in progress
- Slot_Done  out  1  one-cycle pulse when the slot completes
- Cfg_Err  out  1  one-cycle pulse when a slot request is rejected
- Timeout_Err  out  1  one-cycle pulse when the watchdog expires
- Overrun  out  1  one-cycle pulse when Slot_Start arrives while Busy

## Operation
- States: IDLE, DMRS_REQ, DMRS_WAIT, FFT_REQ, FFT_WAIT, DONE.
- All outputs are registered. Reset value of every output is 0, and the state after reset is IDLE.
- IDLE: on Slot_Start, evaluate the inputs combinationally.
  - Valid when all of: 1 ≤ Cfg_N_rb ≤ 100; Cfg_N_sc + 12·Cfg_N_rb ≤ 1200, computed at 12-bit width with no truncation; Cfg_Sym_Start ≤ Cfg_Sym_End ≤ 13.
  - If valid: latch the config outputs, set Sym_Idx = Cfg_Sym_Start, Busy = 1, go to DMRS_REQ.
  - If invalid: pulse Cfg_Err, latch nothing, stay in IDLE.
- DMRS_REQ: DMRS_Start = 1 for exactly this cycle, clear the watchdog, go to DMRS_WAIT.
- DMRS_WAIT, on Map_Sym_Done:
  - if Sym_Idx == Sym_End, go to DONE;
  - otherwise increment Sym_Idx and go to FFT_REQ.
- FFT_REQ: FFT_Start = 1 for exactly this cycle, clear the watchdog, go to FFT_WAIT.
- FFT_WAIT, on Map_Sym_Done:
  - if Sym_Idx == Sym_End, go to DONE;
  - otherwise increment Sym_Idx and go to FFT_REQ.
- DONE: Slot_Done = 1 and Busy = 0 in this cycle, then go to IDLE. Latched config outputs keep their values until the next accepted Slot_Start.
- Watchdog:
  - Counts only in DMRS_WAIT and FFT_WAIT.
  - When it reaches TIMEOUT_CYC without Map_Sym_Done: pulse Timeout_Err, go to IDLE, Busy = 0, Sym_Idx = 0.
- Abort: in any non-IDLE state, go to IDLE next cycle with Busy = 0 and Sym_Idx = 0; no error pulse.
- Boundary rules:
  - Map_Sym_Done and watchdog expiry in the same cycle: completion wins.
  - Map_Sym_Done in IDLE, DMRS_REQ, FFT_REQ or DONE: ignored.
  - Abort and Map_Sym_Done in the same cycle: Abort wins.
  - Abort and Slot_Start in the same cycle in IDLE: Slot_Start is ignored.
  - Slot_Start while Busy (any non-IDLE state, DONE included): pulse Overrun; the running slot is unaffected.
  - Single-symbol slot (Sym_Start == Sym_End): DMRS only, no FFT_Start is issued.
  - Reset asserted mid-slot: every output returns to 0 immediately (asynchronous); no Slot_Done is issued.

## Timing
- Slot_Start sampled at edge 0 → DMRS_Start high during cycle 1.
- Map_Sym_Done sampled at edge k → FFT_Start (or Slot_Done) high during cycle k+1.
- Minimum slot length: 2·(number of symbols) + 1 cycles, excluding mapper latency.
- Timeout latency: Timeout_Err asserts TIMEOUT_CYC cycles after entering a WAIT state.

## Test plan
- Valid slot (N_sc=24, N_rb=4, Sym 2..5), with Map_Sym_Done returned 50 cycles after each start → required response:
  - 1 DMRS_Start, then 3 FFT_Start pulses with Sym_Idx=3,4,5;
  - Slot_Done one cycle after the 4th Map_Sym_Done;
  - Busy falls in that same cycle.
- Single-symbol slot (Sym 7..7) → required response: DMRS_Start only, Slot_Done one cycle after Map_Sym_Done, zero FFT_Start pulses.
- Each invalid request → Cfg_Err pulse, Busy stays 0, config outputs unchanged:
  - N_rb=0;
  - N_sc=1100 with N_rb=10 (sum 1220);
  - Sym_Start=9 with Sym_End=4.
- TIMEOUT_CYC=20, no Map_Sym_Done after FFT_Start → Timeout_Err exactly 20 cycles after entering FFT_WAIT, state returns to IDLE.
- Abort during the second FFT_WAIT of a slot → Busy=0 next cycle, no Slot_Done; a new Slot_Start then runs a clean slot.
- Slot_Start pulsed while in DMRS_WAIT → Overrun pulse, current Sym_Idx and latched config unchanged; slot completes normally.
